router_fsm: RTL

Packet-reception controller for the 1x3 router.
- Sequences header decode, payload loading, parity loading and parity check.
- Drives detect_add and write_enb_reg into the synchronizer.
- Drives lfd_state, ld_state, laf_state, full_state and rst_int_reg into the register block.
- Drives busy back to the source to stall it.
- Reacts to per-FIFO empty flags, the synchronizer's fifo_full and soft resets.

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_fsm.sv | 112 +++++++++++
 2 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: FSM state encoding and destination address codes.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } router_state_e;

  localparam logic [1:0] ADDR_P0      = 2'b00;
  localparam logic [1:0] ADDR_P1      = 2'b01;
  localparam logic [1:0] ADDR_P2      = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // True when the header carries one of the three real destinations.
  function automatic logic addr_is_valid(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router: header decode, payload,
// parity load and parity check, with stall handling on a full FIFO.
module router_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  router_state_e state, next_state;
  logic [1:0]    addr_q;
  logic          empty_hdr;    // empty flag of the FIFO named by data_in
  logic          empty_lat;    // empty flag of the latched destination
  logic          soft_lat;     // soft reset of the latched destination

  // Select per-FIFO flags by the incoming header and by the latched address.
  always_comb begin
    empty_hdr = 1'b0;
    empty_lat = 1'b0;
    soft_lat  = 1'b0;
    case (data_in)
      ADDR_P0: empty_hdr = fifo_empty_0;
      ADDR_P1: empty_hdr = fifo_empty_1;
      ADDR_P2: empty_hdr = fifo_empty_2;
      default: empty_hdr = 1'b0;
    endcase
    case (addr_q)
      ADDR_P0: begin empty_lat = fifo_empty_0; soft_lat = soft_reset_0; end
      ADDR_P1: begin empty_lat = fifo_empty_1; soft_lat = soft_reset_1; end
      ADDR_P2: begin empty_lat = fifo_empty_2; soft_lat = soft_reset_2; end
      default: begin empty_lat = 1'b0;         soft_lat = 1'b0;         end
    endcase
  end

  // State register and destination latch; the latch only loads on a valid header.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= DECODE_ADDRESS;
      addr_q <= ADDR_P0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && pkt_valid && addr_is_valid(data_in))
        addr_q <= data_in;
    end
  end

  // Next-state logic; a soft reset of the latched FIFO overrides every transition.
  always_comb begin
    next_state = state;
    if (state != DECODE_ADDRESS && soft_lat) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (pkt_valid && addr_is_valid(data_in))
            next_state = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (empty_lat) next_state = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          next_state = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) next_state = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) next_state = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        next_state = DECODE_ADDRESS;
          else if (low_pkt_valid) next_state = LOAD_PARITY;
          else                    next_state = LOAD_DATA;
        LOAD_PARITY:
          next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode from the current state only.
  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                    (state == LOAD_AFTER_FULL);
    busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
  end

endmodule
